modcnt: RTL
===========

# modcnt

Parametrised synchronous up/down modulo counter.
- Register built from W toggle-flip-flop bit cells.
- Generalises the team's fixed 3-bit loadable up-counter: configurable width and modulus, direction control, wrap or saturate mode, synchronous clear and cascade outputs.
- Intended use: timebase dividers, BCD/decade chains and event counters; instances chain through `tc` into the next stage's `en`.

## Interface
- `W`, 8: counter width in bits; legal range 2..32.
- `MOD`, 2**W: count modulus; q ranges 0..MOD-1; legal range 2..2**W (elaboration error otherwise).
- `clk` in 1: single clock; all state changes on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `en` in 1: count enable.
- `up` in 1: direction; 1 counts up, 0 counts down.
- `mode` in 1: overflow behaviour; 0 wraps (CNT_WRAP), 1 saturates (CNT_SAT).
- `sclr` in 1: synchronous clear to 0.
- `load` in 1: synchronous parallel load.
- `d` in W: load value.
- `q` out W: current count.
- `tc` out 1: terminal count, combinational.
- `co` out 1: registered wrap pulse.

## Operation
- Next-state priority, evaluated on each rising edge: `sclr` > `load` > `en` > hold.
- `sclr`=1: q←0.
- `load`=1: q←d if d<MOD, else q←MOD-1 (out-of-range loads clamp).
- `en`=1, `up`=1: if q<MOD-1 then q←q+1; else wrap mode q←0, saturate mode q holds at MOD-1.
- `en`=1, `up`=0: if q>0 then q←q-1; else wrap mode q←MOD-1, saturate mode q holds at 0.
- Arithmetic is unsigned W-bit; no intermediate overflow allowed when MOD=2**W (compare against MOD-1, never compute MOD in W bits).
- `tc` = `en` & (`up` ? q==MOD-1 : q==0). Independent of `mode`, `sclr` and `load`, so a chained higher stage's `en` sees it in the same cycle.
- `co` set to 1 for exactly one cycle after an edge on which a wrap occurred (wrap mode, `en`, at terminal, no `sclr`/`load`). Cleared on every other edge.
- Saturate mode: `co` never asserts; `tc` stays high while held at the bound with `en`=1.
- `up` may change on any cycle; takes effect on the next edge with no pipeline.
- q values ≥MOD are unreachable except through a W-bit `d` when MOD<2**W, which is clamped.

## Timing
- Reset (`nrst`=0): q=0, co=0 immediately, without waiting for `clk`. `tc` follows combinationally: 1 if `en`&!`up`, else 0.
- Reset mid-count or mid-load aborts the operation. The first rising edge after `nrst` deasserts behaves as a normal edge from q=0.
- Latency: `sclr`/`load`/`en` sampled at edge n, reflected in q after edge n; `co` valid after the same edge as the wrapped q.
- `tc`: combinational path from q, `en`, `up`; no added register latency.
- Simultaneous `sclr` and `load`: clear wins. Simultaneous `load` and `en` at terminal: load wins, no `co`.

## Structure
- Shared package `cnt_pkg` holds:
  - `typedef enum logic {CNT_WRAP=1'b0, CNT_SAT=1'b1} cnt_mode_t`
  - mode constants, reused by future counter/divider blocks.
- Natural sub-module `tcell`: one T flip-flop bit with asynchronous active-low clear (t, clk, nrst → q). Instantiated W times via generate.
- Top-level logic:
  - computes q_next by the priority above;
  - drives each cell's t = q[i] ^ q_next[i];
  - derives `tc` combinationally;
  - holds `co` in a separate flop with the same reset.

## Test plan
- Reset and count: W=4, MOD=10. Assert `nrst`=0 with q at 7 → q=0, co=0 before the next edge. Release, `en`=1 `up`=1 for 12 edges → q 1..9,0,1,2; co high only in the cycle q=0; tc high while q=9.
- Decade wrap down: W=4, MOD=10, q=0, `up`=0, `en`=1 → next q=9, co=1 for one cycle. From q=0 with `mode`=1 → q stays 0 and co=0, but tc=1.
- Load and clamp: W=4, MOD=10. `load`=1 `d`=6 → q=6. `d`=13 → q=9. `sclr`=1 with `load`=1 `d`=5 → q=0.
- Full-range boundary: W=8, MOD=256, q=255, up, wrap → q=0, co=1. Saturate → q=255, co=0.
- Cascade: two W=4 MOD=10 instances, the second's `en` driven by the first's `tc`, count 0→99 → on the 100th edge both wrap to 00 and the second's co=1.
- Direction flip at bound: q=9, `up`=1 for one cycle then `up`=0 with `en`=1 → q sequence 0 (wrap), 9, 8; tc tracks the direction the same cycle.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared counter definitions: overflow-mode encoding and legal width limits,
// reused by the counter and divider family.
package cnt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    localparam int CNT_W_MIN = 2;
    localparam int CNT_W_MAX = 32;

endpackage

// File: rtl/modcnt_tcell.sv
// Single toggle flip-flop bit cell with asynchronous active-low clear.
module tcell (
    input  logic t,
    input  logic clk,
    input  logic nrst,
    output logic q
);

    logic r_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/modcnt.sv
// Parametrised up/down modulo counter built from toggle cells, with wrap or
// saturate overflow, synchronous clear/load and tc/co cascade outputs.
module modcnt
    import cnt_pkg::*;
#(
    parameter int              W   = 8,
    parameter longint unsigned MOD = 64'd1 << W
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         up,
    input  logic         mode,
    input  logic         sclr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         co
);

    if (W < CNT_W_MIN || W > CNT_W_MAX) begin : g_bad_w
        $error("modcnt: W=%0d outside 2..32", W);
    end
    if (MOD < 64'd2 || MOD > (64'd1 << W)) begin : g_bad_mod
        $error("modcnt: MOD=%0d outside 2..2**W", MOD);
    end

    // Top count held in W bits, so MOD=2**W never needs a W+1 bit constant.
    localparam logic [W-1:0] MAX = W'(MOD - 64'd1);

    cnt_mode_t    w_mode;
    logic [W-1:0] w_q;
    logic [W-1:0] w_q_next;
    logic [W-1:0] w_t;
    logic         w_wrap;
    logic         r_co;

    assign w_mode = cnt_mode_t'(mode);

    // NOTE: defaults assigned first so no path through the block infers a latch.
    always_comb begin
        w_q_next = w_q;
        w_wrap   = 1'b0;
        if (sclr) begin
            w_q_next = '0;
        end else if (load) begin
            w_q_next = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (up) begin
                if (w_q != MAX) begin
                    w_q_next = w_q + 1'b1;
                end else if (w_mode == CNT_WRAP) begin
                    w_q_next = '0;
                    w_wrap   = 1'b1;
                end
            end else begin
                if (w_q != '0) begin
                    w_q_next = w_q - 1'b1;
                end else if (w_mode == CNT_WRAP) begin
                    w_q_next = MAX;
                    w_wrap   = 1'b1;
                end
            end
        end
    end

    assign w_t = w_q ^ w_q_next;

    for (genvar i = 0; i < W; i++) begin : g_cell
        tcell u_cell (
            .t    (w_t[i]),
            .clk  (clk),
            .nrst (nrst),
            .q    (w_q[i])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_co <= 1'b0;
        end else begin
            r_co <= w_wrap;
        end
    end

    assign q  = w_q;
    assign tc = en & (up ? (w_q == MAX) : (w_q == '0));
    assign co = r_co;

endmodule
